// File: rtl/adder_seq_pkg.sv
// rtl/adder_seq_pkg.sv - shared width and FSM state type for adder_rr_sequencer
package adder_seq_pkg;

    localparam int ADD_W = 13;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// rtl/adder.sv - unsigned W-bit adder with carry in/out
// Ports: a, b operands; cin carry in; sum = (a+b+cin) mod 2^W; cout carry out of the MSB.
module adder #(
    parameter int W = 13
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
// Ports: req requests; ptr highest-priority index; gnt one-hot grant;
//        gnt_idx index of the grant; any high when some request is granted.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    // Scan N positions starting at ptr; the first asserted request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any && req[idx]) begin
                any      = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/adder_rr_sequencer.sv
// rtl/adder_rr_sequencer.sv - round-robin sharing of one adder between NUM_REQ requesters
// Ports: clk, rst (sync, active high); req_valid/req_ready per-requester handshake
//        with operands packed 13 bits per requester in req_a/req_b; response channel
//        rsp_valid/rsp_ready carrying rsp_id, rsp_sum, rsp_cout.
module adder_rr_sequencer
    import adder_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [ADD_W*NUM_REQ-1:0]   req_a,
    input  logic [ADD_W*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       rsp_valid,
    output logic [ID_W-1:0]            rsp_id,
    output logic [ADD_W-1:0]           rsp_sum,
    output logic                       rsp_cout,
    input  logic                       rsp_ready
);

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ADD_W-1:0]  op_a;
    logic [ADD_W-1:0]  op_b;
    logic [ID_W-1:0]   op_id;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic               grant_fire;
    logic [ID_W-1:0]    ptr_nxt;

    logic [ADD_W-1:0]   add_sum;
    logic               add_cout;

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .any     (arb_any)
    );

    adder #(
        .W (ADD_W)
    ) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Explicit wrap so non-power-of-two NUM_REQ never produces an out-of-range pointer.
    assign ptr_nxt = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

    // Grants are only offered from IDLE, and never while reset is asserted.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        grant_fire = 1'b0;
        case (state)
            IDLE: begin
                if (!rst && arb_any) begin
                    req_ready  = arb_gnt;
                    grant_fire = 1'b1;
                    state_nxt  = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_fire) begin
                op_a   <= req_a[ADD_W*arb_idx +: ADD_W];
                op_b   <= req_b[ADD_W*arb_idx +: ADD_W];
                op_id  <= arb_idx;
                rr_ptr <= ptr_nxt;
            end
            if (state == EXEC) begin
                rsp_sum   <= add_sum;
                rsp_cout  <= add_cout;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adder_rr_sequencer.sv
// tb/tb_adder_rr_sequencer.sv - self-checking bench for adder_rr_sequencer
module tb_adder_rr_sequencer;

    localparam int N = 4;
    localparam int W = 13;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [W*N-1:0] req_a;
    logic [W*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ready;

    int tests = 0;
    int fails = 0;
    int ptr_m = 0;

    adder_rr_sequencer #(.NUM_REQ(N), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ready (rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input int a, input int b);
        req_a[W*i +: W] = W'(a);
        req_b[W*i +: W] = W'(b);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            chk("reset req_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        ptr_m = 0;
    endtask

    task automatic check_rsp(input string tag, input int g, input int s);
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_id"}, rsp_id, g);
        chk({tag, " rsp_sum"}, rsp_sum, s % 8192);
        chk({tag, " rsp_cout"}, rsp_cout, s / 8192);
        chk({tag, " busy req_ready"}, req_ready, 0);
    endtask

    // Entered and left at posedge+1 with the DUT in IDLE; v must be non-zero.
    task automatic run_op(input string tag, input logic [N-1:0] v, input int hold, input bit scramble);
        int g;
        int s;
        int idx;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr_m + k) % N;
            if (g < 0 && v[idx]) g = idx;
        end
        s = int'(req_a[W*g +: W]) + int'(req_b[W*g +: W]);
        req_valid = v;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, " grant"}, req_ready, 32'(1) << g);
        chk({tag, " idle rsp_valid"}, rsp_valid, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        if (scramble) req_valid = N'($urandom);
        @(negedge clk);
        chk({tag, " exec req_ready"}, req_ready, 0);
        chk({tag, " exec rsp_valid"}, rsp_valid, 0);
        @(posedge clk); #1;
        rsp_ready = (hold == 0);
        @(negedge clk);
        check_rsp(tag, g, s);
        if (hold > 0) begin
            repeat (hold - 1) begin
                @(posedge clk); #1;
                if (scramble) req_valid = N'($urandom);
                @(negedge clk);
                check_rsp({tag, " hold"}, g, s);
            end
            @(posedge clk); #1;
            rsp_ready = 1'b1;
            @(negedge clk);
            check_rsp({tag, " release"}, g, s);
        end
        @(posedge clk); #1;
        chk({tag, " done rsp_valid"}, rsp_valid, 0);
        ptr_m = (g + 1) % N;
    endtask

    initial begin
        int a;
        int b;
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk); #1;

        // Reset held 3 cycles with requests present, then idle.
        do_reset(3);
        req_valid = '0;
        repeat (3) begin
            @(negedge clk);
            chk("idle req_ready", req_ready, 0);
            chk("idle rsp_valid", rsp_valid, 0);
            chk("idle rsp_sum", rsp_sum, 0);
            chk("idle rsp_id", rsp_id, 0);
            chk("idle rsp_cout", rsp_cout, 0);
            @(posedge clk); #1;
        end

        // Basic op, then overflow cases.
        set_op(0, 100, 23);
        run_op("t2 req0", 4'b0001, 0, 1'b0);
        set_op(2, 8191, 1);
        run_op("t3 req2", 4'b0100, 0, 1'b0);
        set_op(1, 4096, 4096);
        run_op("t3 req1", 4'b0010, 0, 1'b0);

        // All valid continuously from a fresh pointer: 0,1,2,3,0,1 back to back.
        do_reset(1);
        for (int i = 0; i < N; i++) set_op(i, 1000 * i + 7, 3 * i + 1);
        for (int i = 0; i < 6; i++) run_op("t4 rotate", 4'b1111, 0, 1'b0);

        // Backpressure for 5 cycles, then next grant directly after release.
        set_op(2, 5000, 4000);
        run_op("t5 hold", 4'b0100, 5, 1'b1);
        run_op("t5 after", 4'b0100, 0, 1'b0);

        // Reset in EXEC: in-flight op is dropped and the pointer returns to 0.
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t6 grant req1", req_ready, 32'h2);
        @(posedge clk); #1;
        rst = 1'b1;
        req_valid = '0;
        @(negedge clk);
        chk("t6 rst req_ready", req_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        ptr_m = 0;
        repeat (2) begin
            @(negedge clk);
            chk("t6 no rsp_valid", rsp_valid, 0);
            chk("t6 rsp_sum", rsp_sum, 0);
            chk("t6 rsp_id", rsp_id, 0);
            @(posedge clk); #1;
        end
        set_op(1, 11, 22);
        set_op(3, 33, 44);
        run_op("t6 scan from 0", 4'b1010, 0, 1'b0);
        run_op("t6 req3", 4'b1000, 0, 1'b0);

        // Randomized traffic with idle gaps, backpressure and request churn.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                a = ($urandom_range(0, 3) == 0) ? 8191 : int'($urandom_range(0, 8191));
                b = ($urandom_range(0, 3) == 0) ? 8191 : int'($urandom_range(0, 8191));
                set_op(i, a, b);
            end
            run_op("rand", N'($urandom_range(1, 15)), int'($urandom_range(0, 2)), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                req_valid = '0;
                @(negedge clk);
                chk("rand gap req_ready", req_ready, 0);
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
